mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit for the EX stage.
//   clk, reset      : single clock, synchronous active-high reset
//   md_valid, md_op : EX instruction is a mult/div-class op and its opcode
//                     (0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   src_a, src_b    : forwarded rs / rt operands
//   rd_hi           : md_out select, 1 = HI, 0 = LO
//   busy            : operation in flight (counter nonzero)
//   hi, lo          : architectural HI/LO registers
//   md_out          : combinational rd_hi ? hi : lo
// The arithmetic is combinational on the latched operands; the counter only
// models the architectural latency (5 cycles mult, 10 cycles div).
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Power-up values match the reset values.
  logic [3:0]  cnt_q = '0;
  logic [2:0]  op_q  = '0;
  logic [31:0] a_q   = '0;
  logic [31:0] b_q   = '0;
  logic [31:0] hi_q  = '0;
  logic [31:0] lo_q  = '0;
  logic [3:0]  cnt_d;
  logic [2:0]  op_d;
  logic [31:0] a_d, b_d, hi_d, lo_d;

  // Result datapath on latched operands.
  logic [63:0] prod;
  logic        is_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    // Low 64 bits of the product of the sign-/zero-extended operands give
    // the signed / unsigned 64-bit result directly.
    if (op_q == OP_MULT)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide via magnitudes: 0x80000000 / -1 falls out naturally as
    // 0x80000000 with remainder 0, with no overflow special case.
    is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
    a_neg  = (op_q == OP_DIV) && a_q[31];
    b_neg  = (op_q == OP_DIV) && b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;  // divide-by-zero result is discarded
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    res_wr = !(is_div && (b_q == 32'd0));
    if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != 4'd0) begin
      // Busy: all md_valid requests are ignored.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && res_wr) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else if (md_valid) begin
      case (md_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          cnt_d = (md_op == OP_DIV || md_op == OP_DIVU) ? 4'd10 : 4'd5;
          op_d  = md_op;
          a_d   = src_a;
          b_d   = src_b;
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy   = (cnt_q != 4'd0);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = rd_hi ? hi_q : lo_q;
endmodule
